// File: rtl/bitwise_accum.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_accum
// Description : Folds a frame of operand beats into one result with a
//               bitwise AND / OR / XOR / NAND reduction selected by the first
//               beat. Frames close on in_last or are truncated at MAX_LEN
//               beats (flagged by out_err). The result is held with
//               backpressure until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_accum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    // State encoding
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ACCUM = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    // Operation encoding
    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_XOR  = 2'b10;
    localparam logic [1:0] c_OP_NAND = 2'b11;

    // Beat count at which an unterminated frame is cut off
    localparam logic [CW-1:0] c_MAX_COUNT = CW'(MAX_LEN);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_op;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_fold;
    logic [CW-1:0]    w_count_inc;

    // Handshake is qualified by the registered ready so nothing is taken
    // while reset is asserted or while a result is pending.
    assign w_accept    = in_valid & r_in_ready;
    assign w_count_inc = r_count + CW'(1);

    // Combine the running accumulator with the new beat using the latched op.
    // NAND accumulates as AND; the inversion is applied once on the output.
    always_comb begin
        w_fold = r_acc & in_data;
        case (r_op)
            c_OP_AND:  w_fold = r_acc & in_data;
            c_OP_OR:   w_fold = r_acc | in_data;
            c_OP_XOR:  w_fold = r_acc ^ in_data;
            c_OP_NAND: w_fold = r_acc & in_data;
            default:   w_fold = r_acc & in_data;
        endcase
    end

    // Frame FSM: accumulate beats, close on last or truncation, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_op        <= c_OP_AND;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_acc   <= in_data;
                        r_count <= CW'(1);
                        r_op    <= op;
                        r_err   <= 1'b0;
                        if (in_last) begin
                            r_state     <= c_S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= c_S_ACCUM;
                        end
                    end
                end

                c_S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_fold;
                        r_count <= w_count_inc;
                        if (in_last) begin
                            r_state     <= c_S_DONE;
                            r_err       <= 1'b0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else if (w_count_inc == c_MAX_COUNT) begin
                            r_state     <= c_S_DONE;
                            r_err       <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                c_S_DONE: begin
                    if (out_ready) begin
                        r_state     <= c_S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= c_S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result presentation; registers only change outside DONE, so the
    // outputs are stable while out_valid is high.
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = (r_op == c_OP_NAND) ? ~r_acc : r_acc;
    assign out_count = r_count;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_accum
// Description : Directed self-checking bench for bitwise_accum with
//               WIDTH=8, MAX_LEN=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] op;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    bitwise_accum #(
        .WIDTH   (8),
        .MAX_LEN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat, confirm it can be taken, and let one edge accept it.
    task automatic beat(input logic [1:0] o, input logic [7:0] d, input logic l);
        op       = o;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        chk("beat_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] d,
                                 input logic [2:0] c, input logic e);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_ready0"}, in_ready, 1'b0);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_err"}, out_err, e);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, out_valid, 1'b0);
        chk({tag, "_consumed_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        op        = 2'b00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_count", out_count, 3'd0);
        chk("rst_out_err", out_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // AND frame: F0 & 3C & FF = 30
        beat(2'b00, 8'hF0, 1'b0);
        chk("and_mid_valid", out_valid, 1'b0);
        beat(2'b00, 8'h3C, 1'b0);
        beat(2'b00, 8'hFF, 1'b1);
        expect_result("and", 8'h30, 3'd3, 1'b0);
        consume("and");

        // XOR single-beat frame
        beat(2'b10, 8'hA5, 1'b1);
        expect_result("xor1", 8'hA5, 3'd1, 1'b0);
        consume("xor1");

        // NAND frame; op change on the second beat must be ignored
        beat(2'b11, 8'hFF, 1'b0);
        beat(2'b01, 8'h0F, 1'b1);
        expect_result("nand", 8'hF0, 3'd2, 1'b0);
        consume("nand");

        // OR frame truncated at MAX_LEN
        beat(2'b01, 8'h01, 1'b0);
        beat(2'b01, 8'h02, 1'b0);
        beat(2'b01, 8'h04, 1'b0);
        beat(2'b01, 8'h08, 1'b0);
        expect_result("trunc", 8'h0F, 3'd4, 1'b1);
        consume("trunc");
        beat(2'b01, 8'h10, 1'b1);
        expect_result("after_trunc", 8'h10, 3'd1, 1'b0);

        // Backpressure: offered beat must be ignored, outputs held
        op       = 2'b10;
        in_data  = 8'h77;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            expect_result("hold", 8'h10, 3'd1, 1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume("hold");

        // Last beat exactly on MAX_LEN: no error
        beat(2'b10, 8'h01, 1'b0);
        beat(2'b10, 8'h02, 1'b0);
        beat(2'b10, 8'h04, 1'b0);
        beat(2'b10, 8'h08, 1'b1);
        expect_result("maxlast", 8'h0F, 3'd4, 1'b0);
        consume("maxlast");

        // Idle gaps inside a frame leave the accumulation untouched
        beat(2'b10, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("gap_valid", out_valid, 1'b0);
            chk("gap_count", out_count, 3'd1);
            chk("gap_data", out_data, 8'h0F);
        end
        beat(2'b10, 8'hF0, 1'b1);
        expect_result("gap", 8'hFF, 3'd2, 1'b0);
        consume("gap");

        // Reset mid-frame discards the partial result
        beat(2'b00, 8'h12, 1'b0);
        beat(2'b00, 8'h34, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_out_count", out_count, 3'd0);
        chk("midrst_out_err", out_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_back", in_ready, 1'b1);
        chk("midrst_no_output", out_valid, 1'b0);
        beat(2'b00, 8'h55, 1'b1);
        expect_result("post_midrst", 8'h55, 3'd1, 1'b0);
        consume("post_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
